// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        BP_BRANCH = 2'd0,
        BP_JUMP   = 2'd1,
        BP_CALL   = 2'd2,
        BP_RET    = 2'd3
    } bp_type_e;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    // Per-entry control fields; valid, tag and target live in their own arrays.
    typedef struct packed {
        bp_type_e   btype;
        logic [1:0] ctr;
    } bp_meta_t;

    function automatic int unsigned btb_entry_width(input int unsigned xlen,
                                                    input int unsigned idx_bits);
        return 1 + (xlen - idx_bits - 2) + xlen + 2 + 2;
    endfunction

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != CTR_ST)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != CTR_SNT)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/bp_return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module bp_return_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      count;

    assign empty = (count == '0);
    assign top   = mem[ptr - PW'(1)];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (count != (PW+1)'(DEPTH))
                count <= count + (PW+1)'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[ptr] <= push_data;
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with 2-bit counters; optional return-address stack
// enabled by defining BP_RAS_EN.
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned RAS_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] predict_pc,
    output logic            predict_taken,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    input  logic [1:0]      update_type,
    output logic [31:0]     hit_count
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    logic [BTB_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_mem [BTB_ENTRIES];
    bp_meta_t               meta    [BTB_ENTRIES];

    logic [IDX-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit;
    bp_meta_t         f_meta, u_meta;
    bp_type_e         u_type;
    logic             upd_en;
    logic [XLEN-1:0]  ras_top;
    logic             ras_empty;
    logic             unused_pc_bits;

    assign f_idx  = fetch_pc[IDX+1:2];
    assign f_tag  = fetch_pc[XLEN-1:IDX+2];
    assign u_idx  = update_pc[IDX+1:2];
    assign u_tag  = update_pc[XLEN-1:IDX+2];
    assign f_meta = meta[f_idx];
    assign u_meta = meta[u_idx];
    assign f_hit  = valid[f_idx] && (tag_mem[f_idx] == f_tag);
    assign u_hit  = valid[u_idx] && (tag_mem[u_idx] == u_tag);
    assign u_type = bp_type_e'(update_type);
    assign upd_en = update_valid && !reset;

    assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

    // Lookup reads the array contents before this cycle's update lands (read-old).
    always_comb begin
        predict_taken = 1'b0;
        predict_pc    = fetch_pc + XLEN'(4);
        if (!reset && f_hit && (f_meta.btype != BP_BRANCH || f_meta.ctr >= CTR_WT)) begin
            predict_taken = 1'b1;
            predict_pc    = tgt_mem[f_idx];
            if (f_meta.btype == BP_RET && !ras_empty)
                predict_pc = ras_top;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (upd_en && update_taken && !u_hit) begin
            valid[u_idx] <= 1'b1;
            meta[u_idx]  <= '{btype: u_type, ctr: CTR_WT};
        end else if (upd_en && u_hit) begin
            meta[u_idx].ctr <= ctr_step(u_meta.ctr, update_taken);
            if (update_taken)
                meta[u_idx].btype <= u_type;
        end
    end

    // Tag is rewritten on taken hits too; it is unchanged there, so one write path suffices.
    always_ff @(posedge clk) begin
        if (upd_en && update_taken) begin
            tag_mem[u_idx] <= u_tag;
            tgt_mem[u_idx] <= update_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            hit_count <= '0;
        else if (upd_en && u_hit && hit_count != '1)
            hit_count <= hit_count + 32'd1;
    end

`ifdef BP_RAS_EN
    bp_return_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (upd_en && update_taken && u_type == BP_CALL),
        .pop       (upd_en && u_type == BP_RET),
        .push_data (update_pc + XLEN'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic [31:0] unused_ras_depth;
    assign unused_ras_depth = 32'(RAS_DEPTH);
    assign ras_top          = '0;
    assign ras_empty        = 1'b1;
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed self-checking bench for branch_predictor_unit (BTB_ENTRIES=64, RAS_DEPTH=2).
module tb_branch_predictor_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic [31:0] predict_pc;
    logic        predict_taken;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [1:0]  update_type;
    logic [31:0] hit_count;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] T_BR = 2'd0, T_JMP = 2'd1, T_CALL = 2'd2, T_RET = 2'd3;

    branch_predictor_unit #(
        .XLEN        (32),
        .BTB_ENTRIES (64),
        .RAS_DEPTH   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_pc      (fetch_pc),
        .predict_pc    (predict_pc),
        .predict_taken (predict_taken),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken),
        .update_type   (update_type),
        .hit_count     (hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic [1:0] ty);
        @(negedge clk);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        update_taken  = tk;
        update_type   = ty;
        @(negedge clk);
        update_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_pc);
        fetch_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_tk});
        check({tag, "_pc"}, predict_pc, exp_pc);
    endtask

    initial begin
        reset = 1'b1; fetch_pc = 32'h100;
        update_valid = 1'b0; update_pc = '0; update_target = '0;
        update_taken = 1'b0; update_type = T_BR;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        look("reset_lookup", 32'h100, 1'b0, 32'h104);
        check("reset_hits", hit_count, 32'd0);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Branch training and counter hysteresis
        upd(32'h200, 32'h180, 1'b1, T_BR);
        look("br_alloc", 32'h200, 1'b1, 32'h180);
        check("br_alloc_hits", hit_count, 32'd0);
        upd(32'h200, 32'h180, 1'b0, T_BR);
        look("br_nt", 32'h200, 1'b0, 32'h204);
        upd(32'h200, 32'h180, 1'b1, T_BR);
        upd(32'h200, 32'h180, 1'b1, T_BR);
        look("br_retaken", 32'h200, 1'b1, 32'h180);
        check("br_hits", hit_count, 32'd3);

        // Aliasing on index 0
        upd(32'h100, 32'h400, 1'b1, T_JMP);
        upd(32'h200, 32'h500, 1'b1, T_JMP);
        look("alias_old", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h200, 1'b1, 32'h500);
        check("alias_hits", hit_count, 32'd3);

        // Not-taken miss does not allocate
        upd(32'h600, 32'h900, 1'b0, T_BR);
        look("nt_miss", 32'h600, 1'b0, 32'h604);

        // Same-cycle read-old
        @(negedge clk);
        update_valid = 1'b1; update_pc = 32'h300; update_target = 32'h340;
        update_taken = 1'b1; update_type = T_JMP;
        look("same_cyc_old", 32'h300, 1'b0, 32'h304);
        @(negedge clk);
        update_valid = 1'b0;
        look("same_cyc_new", 32'h300, 1'b1, 32'h340);

        // Counter clamps: 2->3->3->2->1, then 0->0->1->2
        upd(32'h700, 32'h7a0, 1'b1, T_BR);
        upd(32'h700, 32'h7a0, 1'b1, T_BR);
        upd(32'h700, 32'h7a0, 1'b1, T_BR);
        upd(32'h700, 32'h7a0, 1'b0, T_BR);
        upd(32'h700, 32'h7a0, 1'b0, T_BR);
        look("clamp_hi", 32'h700, 1'b0, 32'h704);
        upd(32'h700, 32'h7a0, 1'b0, T_BR);
        upd(32'h700, 32'h7a0, 1'b0, T_BR);
        upd(32'h700, 32'h7a0, 1'b1, T_BR);
        look("clamp_lo_1", 32'h700, 1'b0, 32'h704);
        upd(32'h700, 32'h7a0, 1'b1, T_BR);
        look("clamp_lo_2", 32'h700, 1'b1, 32'h7a0);
        check("clamp_hits", hit_count, 32'd11);

        // Return handling
        upd(32'h80, 32'h90, 1'b1, T_RET);
`ifdef BP_RAS_EN
        upd(32'h10, 32'h1000, 1'b1, T_CALL);
        upd(32'h20, 32'h1000, 1'b1, T_CALL);
        upd(32'h30, 32'h1000, 1'b1, T_CALL);
        look("ras_top0", 32'h80, 1'b1, 32'h34);
        upd(32'h80, 32'h34, 1'b1, T_RET);
        look("ras_top1", 32'h80, 1'b1, 32'h24);
        upd(32'h80, 32'h24, 1'b1, T_RET);
        look("ras_empty", 32'h80, 1'b1, 32'h24);
        upd(32'h80, 32'h90, 1'b1, T_RET);
        look("ras_underflow", 32'h80, 1'b1, 32'h90);
        check("ras_hits", hit_count, 32'd14);
`else
        look("ret_btb", 32'h80, 1'b1, 32'h90);
        check("ret_hits", hit_count, 32'd11);
`endif

        // Reset mid-training
        upd(32'h1000, 32'h2000, 1'b1, T_JMP);
        upd(32'h1004, 32'h2004, 1'b1, T_JMP);
        upd(32'h1008, 32'h2008, 1'b1, T_JMP);
        look("pre_rst", 32'h1004, 1'b1, 32'h2004);
        @(negedge clk);
        reset = 1'b1;
        update_valid = 1'b1; update_pc = 32'h100c; update_target = 32'h3000;
        update_taken = 1'b1; update_type = T_JMP;
        look("in_rst", 32'h1000, 1'b0, 32'h1004);
        @(negedge clk);
        reset = 1'b0;
        update_valid = 1'b0;
        look("post_rst_a", 32'h1000, 1'b0, 32'h1004);
        look("post_rst_b", 32'h1004, 1'b0, 32'h1008);
        look("post_rst_c", 32'h1008, 1'b0, 32'h100c);
        look("post_rst_ign", 32'h100c, 1'b0, 32'h1010);
        look("post_rst_old", 32'h200, 1'b0, 32'h204);
        check("post_rst_hits", hit_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
